// File: rtl/mnacidpro_sequencer_if.sv
// Host/pad-ring side signal bundle of the purification protocol sequencer.
// The host (master) drives run control and phase durations; the sequencer (slave) drives the pads.
interface mnacidpro_sequencer_if #(
  parameter int SIZE  = 4,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] t_load;
  logic [CNT_W-1:0] t_lysis;
  logic [CNT_W-1:0] t_wash;
  logic [CNT_W-1:0] t_elute;
  logic [10:0]      valve_open;
  logic [2:0]       pump;
  logic [SIZE-1:0]  collect_sel;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [2:0]       state;

  modport master (
    output start, abort, t_load, t_lysis, t_wash, t_elute,
    input  valve_open, pump, collect_sel, busy, done, aborted, state
  );

  modport slave (
    input  start, abort, t_load, t_lysis, t_wash, t_elute,
    output valve_open, pump, collect_sel, busy, done, aborted, state
  );
endinterface

// File: rtl/mnacidpro_sequencer.sv
// Protocol sequencer for the mnacidpro_pads chip: load, lysis, wash, fractioned elution, flush.
// Every pad output is registered from the next-state values so valves change on a state's first cycle.
//
// state | meaning
// IDLE  | waiting for start, all valves closed
// LOAD  | bead load
// LYSIS | lysis buffer through the bead bed
// WASH  | wash buffer to waste
// ELUTE | SIZE fractions, one collect outlet each
// FLUSH | flush to waste, also the landing state after abort
// DONE  | one-cycle completion pulse
module mnacidpro_sequencer #(
  parameter int SIZE      = 4,
  parameter int CNT_W     = 16,
  parameter int PUMP_DIV  = 8,
  parameter int SETTLE    = 4,
  parameter int FLUSH_CYC = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  mnacidpro_sequencer_if.slave ctl
);

  localparam int TW = CNT_W + 1;
  localparam int DW = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
  localparam int FW = (SIZE > 1) ? $clog2(SIZE) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_LYSIS = 3'd2;
  localparam logic [2:0] S_WASH  = 3'd3;
  localparam logic [2:0] S_ELUTE = 3'd4;
  localparam logic [2:0] S_FLUSH = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [10:0] V_LOAD    = 11'h2E0;
  localparam logic [10:0] V_LYSIS   = 11'h111;
  localparam logic [10:0] V_WASH    = 11'h262;
  localparam logic [10:0] V_ELUTE   = 11'h624;
  localparam logic [10:0] V_FLUSH   = 11'h078;
  localparam logic [10:0] V_COLLECT = 11'h400;

  localparam logic [TW-1:0] SETTLE_T  = TW'(SETTLE);
  localparam logic [TW-1:0] FLUSH_T   = TW'(FLUSH_CYC);
  localparam logic [TW-1:0] FLUSH_LEN = SETTLE_T + FLUSH_T - TW'(1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(PUMP_DIV - 1);
  localparam logic [FW-1:0] FRAC_LAST = FW'(SIZE - 1);

  logic [2:0]       state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [FW-1:0]    frac_q, frac_d;
  logic [DW-1:0]    div_q, div_d;
  logic [1:0]       step_q, step_d;
  logic             pumping_q, pumping_d;
  logic [CNT_W-1:0] tload_q, tload_d;
  logic [CNT_W-1:0] tlysis_q, tlysis_d;
  logic [CNT_W-1:0] twash_q, twash_d;
  logic [CNT_W-1:0] telute_q, telute_d;
  logic             aborted_q, aborted_d;
  logic [10:0]      valve_q, valve_d;
  logic [2:0]       pump_q, pump_d;
  logic [SIZE-1:0]  sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [TW-1:0]    dur_d;
  logic             in_phase;

  // Down-counter loaded with the whole phase length; the last D counts are the pumping window.
  function automatic logic [TW-1:0] phase_len(input logic [CNT_W-1:0] d);
    return SETTLE_T + TW'(d) - TW'(1);
  endfunction

  function automatic logic [2:0] pump_pat(input logic [1:0] s);
    case (s)
      2'd0:    return 3'b011;
      2'd1:    return 3'b110;
      default: return 3'b101;
    endcase
  endfunction

  assign in_phase = (state_q == S_LOAD) || (state_q == S_LYSIS) ||
                    (state_q == S_WASH) || (state_q == S_ELUTE);

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    frac_d    = frac_q;
    aborted_d = aborted_q;
    tload_d   = tload_q;
    tlysis_d  = tlysis_q;
    twash_d   = twash_q;
    telute_d  = telute_q;

    if (state_q == S_IDLE) begin
      if (ctl.start) begin
        state_d   = S_LOAD;
        tload_d   = ctl.t_load;
        tlysis_d  = ctl.t_lysis;
        twash_d   = ctl.t_wash;
        telute_d  = ctl.t_elute;
        aborted_d = 1'b0;
        frac_d    = '0;
        tmr_d     = phase_len(ctl.t_load);
      end
    end else if (in_phase && ctl.abort) begin
      state_d   = S_FLUSH;
      tmr_d     = FLUSH_LEN;
      frac_d    = '0;
      aborted_d = 1'b1;
    end else if (tmr_q != '0) begin
      tmr_d = tmr_q - TW'(1);
    end else begin
      case (state_q)
        S_LOAD: begin
          state_d = S_LYSIS;
          tmr_d   = phase_len(tlysis_q);
        end
        S_LYSIS: begin
          state_d = S_WASH;
          tmr_d   = phase_len(twash_q);
        end
        S_WASH: begin
          state_d = S_ELUTE;
          frac_d  = '0;
          tmr_d   = phase_len(telute_q);
        end
        S_ELUTE: begin
          if (frac_q == FRAC_LAST) begin
            state_d = S_FLUSH;
            frac_d  = '0;
            tmr_d   = FLUSH_LEN;
          end else begin
            frac_d = frac_q + FW'(1);
            tmr_d  = phase_len(telute_q);
          end
        end
        S_FLUSH: state_d = aborted_q ? S_IDLE : S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    dur_d = '0;
    case (state_d)
      S_LOAD:  dur_d = TW'(tload_d);
      S_LYSIS: dur_d = TW'(tlysis_d);
      S_WASH:  dur_d = TW'(twash_d);
      S_ELUTE: dur_d = TW'(telute_d);
      S_FLUSH: dur_d = FLUSH_T;
      default: dur_d = '0;
    endcase
    pumping_d = (tmr_d < dur_d);
  end

  // Pump sequence restarts at 3'b011 whenever a pumping window opens.
  always_comb begin
    div_d  = DIV_LAST;
    step_d = 2'd0;
    if (pumping_d && pumping_q) begin
      if (div_q == '0) begin
        step_d = (step_q == 2'd2) ? 2'd0 : step_q + 2'd1;
      end else begin
        div_d  = div_q - DW'(1);
        step_d = step_q;
      end
    end
    pump_d = pumping_d ? pump_pat(step_d) : 3'b000;
  end

  always_comb begin
    valve_d = '0;
    case (state_d)
      S_LOAD:  valve_d = V_LOAD;
      S_LYSIS: valve_d = V_LYSIS;
      S_WASH:  valve_d = V_WASH;
      S_ELUTE: valve_d = pumping_d ? V_ELUTE : (V_ELUTE & ~V_COLLECT);
      S_FLUSH: valve_d = V_FLUSH;
      default: valve_d = '0;
    endcase
    sel_d  = (state_d == S_ELUTE) ? (SIZE'(1) << frac_d) : '0;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      frac_q    <= '0;
      div_q     <= '0;
      step_q    <= '0;
      pumping_q <= 1'b0;
      tload_q   <= '0;
      tlysis_q  <= '0;
      twash_q   <= '0;
      telute_q  <= '0;
      aborted_q <= 1'b0;
      valve_q   <= '0;
      pump_q    <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      frac_q    <= frac_d;
      div_q     <= div_d;
      step_q    <= step_d;
      pumping_q <= pumping_d;
      tload_q   <= tload_d;
      tlysis_q  <= tlysis_d;
      twash_q   <= twash_d;
      telute_q  <= telute_d;
      aborted_q <= aborted_d;
      valve_q   <= valve_d;
      pump_q    <= pump_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign ctl.valve_open  = valve_q;
  assign ctl.pump        = pump_q;
  assign ctl.collect_sel = sel_q;
  assign ctl.busy        = busy_q;
  assign ctl.done        = done_q;
  assign ctl.aborted     = aborted_q;
  assign ctl.state       = state_q;

endmodule

// File: tb/tb_mnacidpro_sequencer.sv
// Directed bench for mnacidpro_sequencer: full run, zero durations, abort, ignored start,
// async reset mid-run, start/abort collision and a maximum-length elution fraction.
module tb_mnacidpro_sequencer;

  localparam int SETTLE = 4;
  localparam int PDIV   = 8;

  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, LYSIS = 3'd2, WASH = 3'd3,
                         ELUTE = 3'd4, FLUSH = 3'd5, DONE = 3'd6;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  mnacidpro_sequencer_if #(.SIZE(4), .CNT_W(16)) bus ();

  mnacidpro_sequencer #(
    .SIZE(4), .CNT_W(16), .PUMP_DIV(PDIV), .SETTLE(SETTLE), .FLUSH_CYC(64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp_pump(input int i);
    int k;
    if (i < SETTLE) return 3'b000;
    k = ((i - SETTLE) / PDIV) % 3;
    if (k == 0) return 3'b011;
    if (k == 1) return 3'b110;
    return 3'b101;
  endfunction

  // Walks n cycles of a phase (full phase when n<0) from its first cycle, checking every output.
  task automatic phase(input string tag, input logic [2:0] st, input logic [10:0] vopen,
                       input logic [3:0] sel, input int d, input int n);
    int bad;
    int first_bad;
    int len;
    logic [10:0] ve;
    bad = 0;
    first_bad = -1;
    len = (n < 0) ? SETTLE + d : n;
    for (int i = 0; i < len; i++) begin
      ve = (st == ELUTE && i < SETTLE) ? (vopen & ~11'h400) : vopen;
      if (bus.state !== st || bus.valve_open !== ve || bus.pump !== exp_pump(i) ||
          bus.collect_sel !== sel || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      step();
    end
    chk($sformatf("%s bad_cycles(first=%0d)", tag, first_bad), bad, 0);
  endtask

  task automatic set_t(input logic [15:0] l, input logic [15:0] y,
                       input logic [15:0] w, input logic [15:0] e);
    bus.t_load = l; bus.t_lysis = y; bus.t_wash = w; bus.t_elute = e;
  endtask

  task automatic check_done_then_idle(input string tag);
    chk({tag, " done_state"}, 32'(bus.state), 32'(DONE));
    chk({tag, " done_pulse"}, 32'(bus.done), 1);
    chk({tag, " done_busy"}, 32'(bus.busy), 1);
    chk({tag, " done_valves"}, 32'(bus.valve_open), 0);
    step();
    chk({tag, " idle_state"}, 32'(bus.state), 32'(IDLE));
    chk({tag, " idle_done"}, 32'(bus.done), 0);
    chk({tag, " idle_busy"}, 32'(bus.busy), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_t(16'd0, 16'd0, 16'd0, 16'd0);
    step();
    step();
    chk("rst state", 32'(bus.state), 0);
    chk("rst valves", 32'(bus.valve_open), 0);
    chk("rst pump", 32'(bus.pump), 0);
    chk("rst sel", 32'(bus.collect_sel), 0);
    chk("rst busy_done_aborted", {29'd0, bus.busy, bus.done, bus.aborted}, 0);
    rst_n = 1'b1;
    step();

    // Full run, all durations 20.
    set_t(16'd20, 16'd20, 16'd20, 16'd20);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("run busy", 32'(bus.busy), 1);
    phase("run load", LOAD, 11'h2E0, 4'h0, 20, -1);
    phase("run lysis", LYSIS, 11'h111, 4'h0, 20, -1);
    phase("run wash", WASH, 11'h262, 4'h0, 20, -1);
    for (int k = 0; k < 4; k++) phase($sformatf("run elute%0d", k), ELUTE, 11'h624, 4'(1 << k), 20, -1);
    phase("run flush", FLUSH, 11'h078, 4'h0, 64, -1);
    check_done_then_idle("run");

    // Zero durations: settle-only phases, pump never moves.
    set_t(16'd0, 16'd0, 16'd0, 16'd0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    phase("zero load", LOAD, 11'h2E0, 4'h0, 0, -1);
    phase("zero lysis", LYSIS, 11'h111, 4'h0, 0, -1);
    phase("zero wash", WASH, 11'h262, 4'h0, 0, -1);
    for (int k = 0; k < 4; k++) phase($sformatf("zero elute%0d", k), ELUTE, 11'h624, 4'(1 << k), 0, -1);
    phase("zero flush", FLUSH, 11'h078, 4'h0, 64, -1);
    check_done_then_idle("zero");

    // Abort on the 10th WASH clock.
    set_t(16'd20, 16'd20, 16'd20, 16'd20);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    phase("abt load", LOAD, 11'h2E0, 4'h0, 20, -1);
    phase("abt lysis", LYSIS, 11'h111, 4'h0, 20, -1);
    phase("abt wash", WASH, 11'h262, 4'h0, 20, 9);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abt state", 32'(bus.state), 32'(FLUSH));
    chk("abt aborted", 32'(bus.aborted), 1);
    chk("abt pump", 32'(bus.pump), 0);
    phase("abt flush", FLUSH, 11'h078, 4'h0, 64, -1);
    chk("abt idle", 32'(bus.state), 32'(IDLE));
    chk("abt no_done", 32'(bus.done), 0);
    chk("abt sticky", 32'(bus.aborted), 1);

    // Start while busy and t_lysis changed mid-LOAD are ignored.
    set_t(16'd5, 16'd10, 16'd0, 16'd0);
    bus.start = 1'b1;
    step();
    chk("ign aborted_cleared", 32'(bus.aborted), 0);
    bus.t_lysis = 16'd30;
    phase("ign load", LOAD, 11'h2E0, 4'h0, 5, -1);
    bus.start = 1'b0;
    phase("ign lysis", LYSIS, 11'h111, 4'h0, 10, -1);
    phase("ign wash", WASH, 11'h262, 4'h0, 0, -1);
    for (int k = 0; k < 4; k++) phase($sformatf("ign elute%0d", k), ELUTE, 11'h624, 4'(1 << k), 0, -1);
    phase("ign flush", FLUSH, 11'h078, 4'h0, 64, -1);
    check_done_then_idle("ign");

    // Asynchronous reset mid-LYSIS, observed before any clock edge.
    set_t(16'd20, 16'd20, 16'd20, 16'd20);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    phase("rstmid load", LOAD, 11'h2E0, 4'h0, 20, -1);
    phase("rstmid lysis", LYSIS, 11'h111, 4'h0, 20, 10);
    rst_n = 1'b0;
    #1;
    chk("rstmid valves", 32'(bus.valve_open), 0);
    chk("rstmid pump", 32'(bus.pump), 0);
    chk("rstmid busy", 32'(bus.busy), 0);
    chk("rstmid state", 32'(bus.state), 0);
    step();
    rst_n = 1'b1;
    step();

    // start+abort together in IDLE; one maximum-length elution fraction.
    set_t(16'd0, 16'd0, 16'd0, 16'hFFFF);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("coll state", 32'(bus.state), 32'(LOAD));
    chk("coll aborted", 32'(bus.aborted), 0);
    phase("coll load", LOAD, 11'h2E0, 4'h0, 0, -1);
    phase("coll lysis", LYSIS, 11'h111, 4'h0, 0, -1);
    phase("coll wash", WASH, 11'h262, 4'h0, 0, -1);
    phase("max elute0", ELUTE, 11'h624, 4'h1, 65535, -1);
    chk("max next_sel", 32'(bus.collect_sel), 2);
    chk("max next_state", 32'(bus.state), 32'(ELUTE));
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("max abort_state", 32'(bus.state), 32'(FLUSH));
    chk("max abort_sel", 32'(bus.collect_sel), 0);
    phase("max flush", FLUSH, 11'h078, 4'h0, 64, -1);
    chk("max idle", 32'(bus.state), 32'(IDLE));
    chk("max aborted", 32'(bus.aborted), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
